// File: rtl/spi_arb_pkg.sv
// spi_arb_pkg: shared types and constants for the SPI transaction arbiter.
// Contents: FSM state encoding, default widths, index-width helper.
package spi_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_WAIT  = 2'd2,
      ST_GAP   = 2'd3
   } arb_state_e;

   localparam int DEF_NUM_REQ    = 4;
   localparam int DEF_DATA_W     = 16;
   localparam int DEF_GAP_CYCLES = 2;
   localparam int DEF_TIMEOUT    = 64;

   // Bits needed to index n requesters (never less than 1).
   function automatic int idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/spi_rr_picker.sv
// spi_rr_picker: combinational round-robin selector.
// Ports: i_req (request vector), i_ptr (last winner),
//        o_found (any request), o_idx (first set bit above i_ptr, wrapping).
module spi_rr_picker
   import spi_arb_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int IW      = idx_w(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IW-1:0]      i_ptr,
   output logic               o_found,
   output logic [IW-1:0]      o_idx
);

   logic [IW-1:0] w_pos;

   // Scan ptr+1 .. ptr+NUM_REQ; wrap is modulo NUM_REQ, not 2**IW.
   always_comb begin
      o_found = 1'b0;
      o_idx   = '0;
      w_pos   = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         w_pos = IW'((int'(i_ptr) + k) % NUM_REQ);
         if (!o_found && i_req[w_pos]) begin
            o_found = 1'b1;
            o_idx   = w_pos;
         end
      end
   end

endmodule

// File: rtl/spi_txn_arbiter.sv
// spi_txn_arbiter: round-robin share of one SPI master engine among
// NUM_REQ requesters, with frame latch, start strobe, ack and CS-idle gap.
// Ports: clk, rst (sync, active-high); req/req_data from clients;
//        gnt/ack/err to clients; m_start/m_data/m_cs_sel/m_done to the
//        engine; busy when not idle.
// Optional: define SPI_ARB_TIMEOUT_EN for a WAIT watchdog driving err.
module spi_txn_arbiter
   import spi_arb_pkg::*;
#(
   parameter int NUM_REQ        = DEF_NUM_REQ,
   parameter int DATA_W         = DEF_DATA_W,
   parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        gnt,
   output logic [NUM_REQ-1:0]        ack,
   output logic [NUM_REQ-1:0]        err,
   output logic                      m_start,
   output logic [DATA_W-1:0]         m_data,
   output logic [NUM_REQ-1:0]        m_cs_sel,
   input  logic                      m_done,
   output logic                      busy
);

   localparam int IW = idx_w(NUM_REQ);
   localparam int GW = (GAP_CYCLES < 1) ? 1 : $clog2(GAP_CYCLES + 1);
   localparam logic [IW-1:0] PTR_RST = IW'(NUM_REQ - 1);

   arb_state_e          r_state;
   arb_state_e          w_state_nxt;
   logic [IW-1:0]       r_ptr;
   logic [IW-1:0]       r_idx;
   logic [IW-1:0]       w_idx;
   logic                w_found;
   logic [NUM_REQ-1:0]  r_gnt;
   logic [NUM_REQ-1:0]  r_ack;
   logic [NUM_REQ-1:0]  w_onehot;
   logic [DATA_W-1:0]   r_data;
   logic [GW-1:0]       r_gap_cnt;
   logic                w_grant;
   logic                w_release;
   logic                w_to;

   spi_rr_picker #(
      .NUM_REQ (NUM_REQ),
      .IW      (IW)
   ) u_picker (
      .i_req   (req),
      .i_ptr   (r_ptr),
      .o_found (w_found),
      .o_idx   (w_idx)
   );

   assign w_onehot = NUM_REQ'(1) << w_idx;

`ifdef SPI_ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [TW-1:0]      r_wcnt;
   logic [NUM_REQ-1:0] r_err;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wcnt <= '0;
      end else if (r_state == ST_START) begin
         r_wcnt <= '0;
      end else if (r_state == ST_WAIT) begin
         r_wcnt <= r_wcnt + 1'b1;
      end
   end

   // Limit reached in this WAIT cycle; a coincident m_done wins.
   assign w_to = (r_state == ST_WAIT) && !m_done &&
                 (r_wcnt == TW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_err <= '0;
      end else begin
         r_err <= (w_release && w_to) ? r_gnt : '0;
      end
   end

   assign err = r_err;
`else
   assign w_to = 1'b0;
   assign err  = '0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_grant     = 1'b0;
      w_release   = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (w_found) begin
               w_grant     = 1'b1;
               w_state_nxt = ST_START;
            end
         end
         ST_START: begin
            w_state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            if (m_done || w_to) begin
               w_release   = 1'b1;
               w_state_nxt = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
            end
         end
         ST_GAP: begin
            if (r_gap_cnt <= GW'(1)) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr     <= PTR_RST;
         r_idx     <= '0;
         r_gnt     <= '0;
         r_ack     <= '0;
         r_data    <= '0;
         r_gap_cnt <= '0;
      end else begin
         r_ack <= '0;
         if (w_grant) begin
            r_idx  <= w_idx;
            r_gnt  <= w_onehot;
            r_data <= req_data[int'(w_idx)*DATA_W +: DATA_W];
         end
         if (w_release) begin
            r_ack     <= r_gnt;
            r_gnt     <= '0;
            r_ptr     <= r_idx;
            r_gap_cnt <= GW'(GAP_CYCLES);
         end else if (r_state == ST_GAP) begin
            r_gap_cnt <= r_gap_cnt - 1'b1;
         end
      end
   end

   assign gnt      = r_gnt;
   assign m_cs_sel = r_gnt;
   assign ack      = r_ack;
   assign m_data   = r_data;
   assign m_start  = (r_state == ST_START);
   assign busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// tb_spi_txn_arbiter: directed and randomized checks of spi_txn_arbiter
// against a round-robin reference model kept in the bench.
module tb_spi_txn_arbiter;

   localparam int N  = 4;
   localparam int IW = 2;
   localparam int DW = 16;
   localparam int G  = 2;
   localparam int TO = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  req;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]  gnt;
   logic [N-1:0]  ack;
   logic [N-1:0]  err;
   logic          m_start;
   logic [DW-1:0] m_data;
   logic [N-1:0]  m_cs_sel;
   logic          m_done;
   logic          busy;

   int n_vec = 0;
   int n_bad = 0;
   int cyc   = 0;
   int m_ptr;

   always #5 clk = ~clk;

   spi_txn_arbiter #(
      .NUM_REQ        (N),
      .DATA_W         (DW),
      .GAP_CYCLES     (G),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .req_data (req_data),
      .gnt      (gnt),
      .ack      (ack),
      .err      (err),
      .m_start  (m_start),
      .m_data   (m_data),
      .m_cs_sel (m_cs_sel),
      .m_done   (m_done),
      .busy     (busy)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Reference: first requester after p, counting upward modulo N.
   function automatic int pick(input logic [N-1:0] r, input int p);
      logic [IW-1:0] q;
      for (int k = 1; k <= N; k++) begin
         q = IW'((p + k) % N);
         if (r[q]) return int'(q);
      end
      return -1;
   endfunction

   function automatic logic [N-1:0] oh(input int i);
      return N'(1) << i;
   endfunction

   task automatic chk_start(input string tag, input int w,
                            input logic [DW-1:0] d);
      check({tag, ".m_start"}, m_start, 1);
      check({tag, ".gnt"}, gnt, oh(w));
      check({tag, ".cs_sel"}, m_cs_sel, oh(w));
      check({tag, ".m_data"}, m_data, d);
      check({tag, ".busy"}, busy, 1);
      check({tag, ".ack"}, ack, 0);
   endtask

   // Called while START is visible; returns at the first IDLE cycle.
   task automatic finish_txn(input int w, input logic [DW-1:0] d,
                             input int nwait, input bit d_start,
                             input bit mess, input bit d_gap);
      if (d_start) m_done = 1'b1;
      tick();
      m_done = 1'b0;
      check("wait.m_start", m_start, 0);
      check("wait.ack", ack, 0);
      check("wait.gnt", gnt, oh(w));
      if (mess) begin
         req_data[w*DW +: DW] = ~d;
         req[w] = 1'b0;
      end
      for (int i = 1; i < nwait; i++) begin
         tick();
         check("wait.ack", ack, 0);
         check("wait.data", m_data, d);
      end
      m_done = 1'b1;
      tick();
      m_done = 1'b0;
      check("ack", ack, oh(w));
      check("ack.gnt", gnt, 0);
      check("ack.cs_sel", m_cs_sel, 0);
      check("ack.err", err, 0);
      check("ack.busy", busy, 1);
      check("ack.data", m_data, d);
      if (d_gap) m_done = 1'b1;
      tick();
      m_done = 1'b0;
      check("gap.ack", ack, 0);
      check("gap.busy", busy, 1);
      check("gap.m_start", m_start, 0);
      tick();
      check("idle.busy", busy, 0);
      check("idle.m_start", m_start, 0);
      check("idle.ack", ack, 0);
      m_ptr = w;
   endtask

   initial begin
      int w;
      int prev;
      logic [DW-1:0] d;
      logic [N-1:0] acc;

      rst      = 1'b1;
      req      = '0;
      req_data = '0;
      m_done   = 1'b0;
      m_ptr    = N - 1;
      tick();
      tick();
      check("rst.gnt", gnt, 0);
      check("rst.ack", ack, 0);
      check("rst.err", err, 0);
      check("rst.m_start", m_start, 0);
      check("rst.m_data", m_data, 0);
      check("rst.cs_sel", m_cs_sel, 0);
      check("rst.busy", busy, 0);
      rst = 1'b0;
      tick();
      check("idle0.busy", busy, 0);

      // Single request, long engine transfer.
      req_data[1*DW +: DW] = 16'hA55A;
      req = 4'b0010;
      tick();
      chk_start("t1", 1, 16'hA55A);
      finish_txn(1, 16'hA55A, 33, 1'b0, 1'b0, 1'b0);
      req = '0;

      // Reset in the middle of a transaction.
      for (int i = 0; i < N; i++) req_data[i*DW +: DW] = 16'h1000 + 16'(i);
      req = '1;
      w = pick(req, m_ptr);
      tick();
      chk_start("pre_rst", w, 16'h1000 + 16'(w));
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_rst.gnt", gnt, 0);
      check("mid_rst.ack", ack, 0);
      check("mid_rst.m_start", m_start, 0);
      check("mid_rst.m_data", m_data, 0);
      check("mid_rst.cs_sel", m_cs_sel, 0);
      check("mid_rst.busy", busy, 0);
      m_ptr = N - 1;

      // All requesters held: strict rotation, constant spacing.
      tick();
      prev = 0;
      for (int k = 0; k < 5; k++) begin
         w = pick(req, m_ptr);
         check("rr.order", gnt, oh(k % N));
         chk_start("rr", w, 16'h1000 + 16'(w));
         if (k > 0) check("rr.spacing", cyc - prev, 4 + G);
         prev = cyc;
         finish_txn(w, 16'h1000 + 16'(w), 2, 1'b0, 1'b0, 1'b0);
         if (k == 4) req = '0;
         tick();
      end
      check("rr.idle", busy, 0);

      // Randomized traffic.
      for (int it = 0; it < 40; it++) begin
         for (int i = 0; i < N; i++) begin
            if (!req[i] && $urandom_range(2) == 0) begin
               req_data[i*DW +: DW] = 16'($urandom);
               req[i] = 1'b1;
            end
         end
         if (req == '0) begin
            tick();
            check("rnd.idle", busy, 0);
            check("rnd.nostart", m_start, 0);
            w = $urandom_range(N - 1);
            req_data[w*DW +: DW] = 16'($urandom);
            req[w] = 1'b1;
         end
         w = pick(req, m_ptr);
         d = req_data[w*DW +: DW];
         tick();
         chk_start("rnd", w, d);
         finish_txn(w, d, $urandom_range(6, 1), 1'($urandom_range(1)),
                    1'($urandom_range(1)), 1'($urandom_range(1)));
         if ($urandom_range(1) == 1) req[w] = 1'b0;
      end
      req = '0;
      tick();
      check("rnd.end_idle", busy, 0);

      // Engine never answers.
      req_data[2*DW +: DW] = 16'hBEEF;
      req = 4'b0100;
      tick();
      chk_start("to", 2, 16'hBEEF);
`ifdef SPI_ARB_TIMEOUT_EN
      for (int k = 0; k < TO; k++) begin
         tick();
         check("to.wait_ack", ack, 0);
         check("to.wait_busy", busy, 1);
      end
      req = '0;
      tick();
      check("to.ack", ack, oh(2));
      check("to.err", err, oh(2));
      check("to.gnt", gnt, 0);
      tick();
      check("to.err_pulse", err, 0);
      check("to.gap_busy", busy, 1);
      tick();
      check("to.idle", busy, 0);
`else
      acc = '0;
      for (int k = 0; k < 100; k++) begin
         tick();
         acc = acc | err | ack;
      end
      check("to.no_err", acc, 0);
      check("to.busy", busy, 1);
      check("to.gnt", gnt, oh(2));
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/spi_txn_arbiter.md
Name: spi_txn_arbiter

Overview:
- Shares one 16-bit SPI master engine between NUM_REQ requesters on a single clock.
- Picks requesters round-robin, latches the winner's frame, and drives the engine's start strobe and one-hot chip-select selection.
- Waits for the engine's done pulse, then acknowledges the requester and enforces a minimum CS-idle gap before the next frame.
- Sits between system-side clients (register blocks, sensor pollers) and the SPI shift engine.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 16, frame width in bits.
- GAP_CYCLES, 2, idle clk cycles between frames (0 allowed).
- TIMEOUT_CYCLES, 64, watchdog limit in WAIT (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req  in  NUM_REQ  per-requester transfer request, level
- req_data  in  NUM_REQ*DATA_W  frames; requester i owns slice [i*DATA_W +: DATA_W]
- gnt  out  NUM_REQ  one-hot grant, held for the whole transaction
- ack  out  NUM_REQ  one-cycle completion pulse to the granted requester
- err  out  NUM_REQ  one-cycle timeout pulse; constant 0 without the optional feature
- m_start  out  1  one-cycle start strobe to the SPI engine
- m_data  out  DATA_W  latched frame, stable from START until the next grant
- m_cs_sel  out  NUM_REQ  one-hot chip-select selection, equal to gnt
- m_done  in  1  engine completion pulse
- busy  out  1  high in every state except IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: gnt=0, ack=0, err=0, m_start=0, m_data=0, m_cs_sel=0, busy=0. State=IDLE. Round-robin pointer=NUM_REQ-1, so requester 0 has first priority.
- States: IDLE, START, WAIT, GAP.
- IDLE:
  - If req!=0 in cycle T, pick the winner as the first set bit searching upward from ptr+1, wrapping modulo NUM_REQ.
  - In cycle T+1 the block is in START with gnt, m_cs_sel and m_data registered and m_start=1.
  - Request-to-start latency is exactly 1 cycle.
- START: lasts exactly 1 cycle, then WAIT. m_start is high only in START. m_done is ignored in START.
- WAIT:
  - When m_done=1 in cycle D: in D+1, ack[idx]=1 for one cycle, gnt=0, m_cs_sel=0, and ptr<=idx.
  - Next state is GAP, or IDLE directly if GAP_CYCLES==0.
- GAP:
  - A down-counter loads GAP_CYCLES on WAIT exit.
  - Return to IDLE after exactly GAP_CYCLES cycles in GAP. No grant or start is issued during GAP. Requests are not sampled.
- Requester rules:
  - Hold req and data until ack.
  - req_data is sampled only at the grant edge, so later changes do not affect the frame.
  - Dropping req while granted does not abort; the frame completes and ack still pulses.
  - Re-asserting req in the ack cycle is legal; it competes at the next IDLE.
- Fairness: with all requesters asserting continuously, grants rotate 0,1,...,NUM_REQ-1,0. There is no starvation.
- Simultaneous events: a req edge arriving in the same cycle as ack is ignored until IDLE. m_done outside WAIT is dropped.
- Reset mid-transaction: everything returns to reset values on the next edge. No ack is issued, and the engine is expected to be reset alongside.
- Widths:
  - Pointer and index are $clog2(NUM_REQ) bits.
  - The gap counter is wide enough for GAP_CYCLES.
  - Wrap-around of ptr+1 is modulo NUM_REQ, not a power of two.

Optional Feature:
- Macro: SPI_ARB_TIMEOUT_EN.
- Defined:
  - A WAIT cycle counter is cleared on START.
  - If it reaches TIMEOUT_CYCLES with no m_done, the next cycle pulses ack[idx] and err[idx] together, releases the grant, and goes to GAP as normal.
  - m_done arriving in the same cycle the limit is reached counts as success (no err).
- Undefined: no counter exists, err is tied to 0, and WAIT waits indefinitely.

Decomposition:
- spi_arb_pkg:
  - state encoding (IDLE=0, START=1, WAIT=2, GAP=3, 2 bits)
  - default constants for DATA_W and GAP_CYCLES
  - a function returning index width
- Sub-module spi_rr_picker: combinational round-robin selector.
  - Inputs: req and ptr.
  - Outputs: found and idx.
  - Reused later by other shared-bus arbiters.

Test Plan:
- Reset, then req=4'b0010 with data 16'hA55A: m_start high exactly 1 cycle after req, gnt=m_cs_sel=0010, and m_data=A55A. Pulse m_done 34 cycles later: ack=0010 on the next cycle, then 2 GAP cycles, then IDLE with busy=0.
- req=4'b1111 held, each frame unique (16'h1000+i), m_done returned after 3 cycles: grant order is 0,1,2,3,0. Each m_data matches its requester's data, and the start-to-start spacing is constant.
- Change req_data and drop req during WAIT: m_data is unchanged, and ack still pulses for the original requester.
- m_done pulsed in START and in GAP: ignored. No ack, no state change, and the WAIT exit occurs only on the later m_done.
- Assert rst during WAIT: next cycle all outputs 0 and ptr=3. The next req=1111 grants requester 0 first.
- With SPI_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, never pulse m_done: 8 WAIT cycles, then ack[idx]=err[idx]=1 for one cycle, then GAP. Without the macro, err stays 0 and busy stays 1.
